crossover_engine: RTL and testbench

//  Produces the crossover_gene consumed by perturb_engine: takes two parent genes, picks
//  a crossover point (single-point) or per-gene mask (uniform) from an internal LFSR, and

---
 rtl/crossover_engine.sv | 141 ++++++++++++++
 tb/tb_crossover_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crossover_engine.sv
// Crossover engine: takes a parent pair and builds one child chromosome.
// Single-point mode takes genes below the point from parent A and the rest from B.
// Uniform mode takes gene i from B where mask bit i is set, otherwise from A.
// The point or mask comes either from cfg_sel or from a 16-bit Galois LFSR.
// The LFSR steps exactly once per accepted pair.
module crossover_engine #(
    parameter int          GENE_W    = 8,
    parameter int          NUM_GENES = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        parent_valid,
    output logic                        parent_ready,
    input  logic [GENE_W*NUM_GENES-1:0] parent_a,
    input  logic [GENE_W*NUM_GENES-1:0] parent_b,
    input  logic                        mode,
    input  logic                        cfg_en,
    input  logic [NUM_GENES-1:0]        cfg_sel,
    output logic [GENE_W*NUM_GENES-1:0] crossover_gene,
    output logic                        crossover_valid,
    input  logic                        crossover_ready,
    output logic [15:0]                 xover_count
);

    localparam int CHROM_W = GENE_W * NUM_GENES;
    localparam int PT_W    = $clog2(NUM_GENES);

    typedef enum logic [1:0] {IDLE, SELECT, COMBINE, OUTPUT} state_t;

    state_t               state_reg;
    logic [15:0]          lfsr_reg;
    logic [15:0]          lfsr_next;
    logic [CHROM_W-1:0]   a_reg;
    logic [CHROM_W-1:0]   b_reg;
    logic                 mode_reg;
    logic                 cfg_en_reg;
    logic [NUM_GENES-1:0] cfg_sel_reg;
    // Holds either the crossover point (single) or the gene mask (uniform).
    logic [NUM_GENES-1:0] sel_reg;
    logic [NUM_GENES-1:0] sel_next;
    logic [CHROM_W-1:0]   gene_reg;
    logic [CHROM_W-1:0]   child_next;
    logic [NUM_GENES-1:0] pick_b;
    logic                 valid_reg;
    logic                 ready_reg;
    logic [15:0]          count_reg;
    int                   rand_pt;

    // Galois LFSR step: shift right, fold in the tap mask when the LSB falls out.
    always_comb begin
        lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end

    // Derive the crossover point or mask from the captured config or the stepped LFSR.
    // A random point is folded into 1..NUM_GENES-1 so both parents always contribute.
    always_comb begin
        sel_next = '0;
        rand_pt  = (int'(lfsr_next[PT_W-1:0]) % (NUM_GENES - 1)) + 1;
        if (mode_reg) begin
            sel_next = cfg_en_reg ? cfg_sel_reg : lfsr_next[NUM_GENES-1:0];
        end else if (cfg_en_reg) begin
            if (cfg_sel_reg == '0)
                sel_next = NUM_GENES'(1);
            else if (int'(cfg_sel_reg) >= NUM_GENES)
                sel_next = NUM_GENES'(NUM_GENES - 1);
            else
                sel_next = cfg_sel_reg;
        end else begin
            sel_next = NUM_GENES'(rand_pt);
        end
    end

    // Per-gene source select: B where the mask bit is set, or at/after the point.
    generate
        for (genvar gi = 0; gi < NUM_GENES; gi++) begin : g_gene
            assign pick_b[gi] = mode_reg ? sel_reg[gi] : (gi >= int'(sel_reg));
            assign child_next[GENE_W*gi +: GENE_W] = pick_b[gi] ? b_reg[GENE_W*gi +: GENE_W]
                                                                : a_reg[GENE_W*gi +: GENE_W];
        end
    endgenerate

    // Control FSM with registered handshake outputs; ready never feeds valid combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            lfsr_reg    <= LFSR_SEED;
            a_reg       <= '0;
            b_reg       <= '0;
            mode_reg    <= 1'b0;
            cfg_en_reg  <= 1'b0;
            cfg_sel_reg <= '0;
            sel_reg     <= '0;
            gene_reg    <= '0;
            valid_reg   <= 1'b0;
            ready_reg   <= 1'b0;
            count_reg   <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (parent_valid && ready_reg) begin
                        a_reg       <= parent_a;
                        b_reg       <= parent_b;
                        mode_reg    <= mode;
                        cfg_en_reg  <= cfg_en;
                        cfg_sel_reg <= cfg_sel;
                        ready_reg   <= 1'b0;
                        state_reg   <= SELECT;
                    end else begin
                        ready_reg   <= 1'b1;
                    end
                end
                SELECT: begin
                    lfsr_reg  <= lfsr_next;
                    sel_reg   <= sel_next;
                    state_reg <= COMBINE;
                end
                COMBINE: begin
                    gene_reg  <= child_next;
                    valid_reg <= 1'b1;
                    state_reg <= OUTPUT;
                end
                OUTPUT: begin
                    if (crossover_ready) begin
                        valid_reg <= 1'b0;
                        count_reg <= count_reg + 16'h0001;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign parent_ready    = ready_reg;
    assign crossover_gene  = gene_reg;
    assign crossover_valid = valid_reg;
    assign xover_count     = count_reg;

endmodule

// File: tb/tb_crossover_engine.sv
// Bench for crossover_engine: a transaction-level reference model (one LFSR step
// per accepted pair, child built from gene arrays), checked every cycle, plus
// directed cases with hand-computed children.
module tb_crossover_engine;

    localparam logic [31:0] PA = 32'h04030201;
    localparam logic [31:0] PB = 32'h08070605;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        parent_valid = 1'b0;
    logic        parent_ready;
    logic [31:0] parent_a = '0;
    logic [31:0] parent_b = '0;
    logic        mode = 1'b0;
    logic        cfg_en = 1'b0;
    logic [3:0]  cfg_sel = '0;
    logic [31:0] crossover_gene;
    logic        crossover_valid;
    logic        crossover_ready = 1'b0;
    logic [15:0] xover_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crossover_engine #(.GENE_W(8), .NUM_GENES(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst),
        .parent_valid(parent_valid), .parent_ready(parent_ready),
        .parent_a(parent_a), .parent_b(parent_b),
        .mode(mode), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
        .crossover_gene(crossover_gene), .crossover_valid(crossover_valid),
        .crossover_ready(crossover_ready), .xover_count(xover_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] lf);
        logic [15:0] nxt;
        nxt = lf >> 1;
        if (lf[0]) nxt = nxt ^ 16'hB400;
        return nxt;
    endfunction

    function automatic logic [31:0] model_child(input logic [31:0] a, input logic [31:0] b,
                                                input logic m, input logic en,
                                                input logic [3:0] sel, input logic [15:0] lf);
        logic [7:0]  ga [4];
        logic [7:0]  gb [4];
        logic [31:0] child;
        logic [3:0]  mask;
        int          p;
        bit          use_b;
        mask = en ? sel : lf[3:0];
        if (en) p = (sel == 0) ? 1 : ((int'(sel) >= 4) ? 3 : int'(sel));
        else    p = (int'(lf[1:0]) % 3) + 1;
        child = '0;
        for (int i = 0; i < 4; i++) begin
            ga[i] = a[8*i +: 8];
            gb[i] = b[8*i +: 8];
            use_b = m ? mask[i] : (i >= p);
            child[8*i +: 8] = use_b ? gb[i] : ga[i];
        end
        return child;
    endfunction

    // Reference model, advanced on every rising edge from the bench's own inputs.
    typedef struct {
        logic [31:0] child;
        int          due;
    } item_t;

    item_t       q[$];
    int          cyc = 0;
    bit          started = 0;
    bit          ready_m = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    logic [15:0] count_m = 16'h0000;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            q.delete();
            lfsr_m  = 16'hACE1;
            count_m = 16'h0000;
            ready_m = 0;
        end else begin
            if (q.size() > 0 && cyc >= q[0].due && crossover_ready) begin
                void'(q.pop_front());
                count_m = count_m + 16'h0001;
            end else if (parent_valid && ready_m) begin
                lfsr_m = lfsr_step(lfsr_m);
                q.push_back('{child: model_child(parent_a, parent_b, mode, cfg_en, cfg_sel, lfsr_m),
                              due: cyc + 3});
            end
            ready_m = (q.size() == 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_valid;
        if (started) begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].due - 1);
            chk("m_valid", crossover_valid, exp_valid);
            chk("m_ready", parent_ready, ready_m);
            chk("m_count", xover_count, count_m);
            if (exp_valid) chk("m_gene", crossover_gene, q[0].child);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_only(input logic [31:0] a, input logic [31:0] b,
                             input logic m, input logic en, input logic [3:0] s);
        int n;
        n = 0;
        while (!parent_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", parent_ready, 1);
        parent_a = a; parent_b = b; mode = m; cfg_en = en; cfg_sel = s;
        parent_valid = 1'b1;
        @(negedge clk);
        parent_valid = 1'b0;
        // Scramble inputs after accept; the in-flight child must not change.
        parent_a = $urandom; parent_b = $urandom; mode = ~m; cfg_sel = 4'($urandom);
    endtask

    task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                            input logic m, input logic en, input logic [3:0] s,
                            input logic [31:0] want, input int hold);
        int n;
        send_only(a, b, m, en, s);
        n = 0;
        while (!crossover_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 2);
        chk("child", crossover_gene, want);
        repeat (hold) begin
            parent_valid = 1'b1;
            parent_a = $urandom;
            @(negedge clk);
            chk("bp_gene", crossover_gene, want);
            chk("bp_ready", parent_ready, 0);
        end
        parent_valid = 1'b0;
        crossover_ready = 1'b1;
        @(negedge clk);
        crossover_ready = 1'b0;
        chk("valid_drop", crossover_valid, 0);
    endtask

    initial begin
        int n;
        // Pin the model itself against hand-computed values.
        chk("model_lfsr1", lfsr_step(16'hACE1), 16'hE270);
        chk("model_single", model_child(PA, PB, 1'b0, 1'b1, 4'd2, 16'h0), 32'h08070201);
        chk("model_clamp", model_child(PA, PB, 1'b0, 1'b1, 4'd9, 16'h0), 32'h08030201);

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", crossover_valid, 0);
        chk("rst_gene", crossover_gene, 0);
        chk("rst_count", xover_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", parent_ready, 1);

        // Forced single-point, including clamp of cfg_sel=0 and cfg_sel>=NUM_GENES.
        run_pair(PA, PB, 1'b0, 1'b1, 4'd2, 32'h08070201, 0);
        run_pair(PA, PB, 1'b0, 1'b1, 4'd0, 32'h08070601, 0);
        run_pair(PA, PB, 1'b0, 1'b1, 4'd7, 32'h08030201, 0);

        // Forced uniform, including all-0 and all-1 masks.
        run_pair(PA, PB, 1'b1, 1'b1, 4'b1010, 32'h08030601, 0);
        run_pair(PA, PB, 1'b1, 1'b1, 4'b1111, 32'h08070605, 0);
        run_pair(PA, PB, 1'b1, 1'b1, 4'b0000, 32'h04030201, 0);

        // Backpressure: hold ready low 10 cycles with a competing parent_valid.
        do_reset();
        run_pair(PA, PB, 1'b1, 1'b1, 4'b1111, 32'h08070605, 10);
        chk("bp_count", xover_count, 1);

        // LFSR-driven uniform masks from the seed: 4'h0, 4'h8, 4'hC.
        do_reset();
        run_pair(PA, PB, 1'b1, 1'b0, 4'h5, 32'h04030201, 0);
        run_pair(PA, PB, 1'b1, 1'b0, 4'h5, 32'h08030201, 0);
        run_pair(PA, PB, 1'b1, 1'b0, 4'h5, 32'h08070201, 0);

        // Reset while a child is held in OUTPUT.
        do_reset();
        send_only(PA, PB, 1'b0, 1'b1, 4'd3);
        n = 0;
        while (!crossover_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_pre_valid", crossover_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", crossover_valid, 0);
        chk("midrst_count", xover_count, 0);
        rst = 1'b0;
        run_pair(PA, PB, 1'b1, 1'b0, 4'h5, 32'h04030201, 0);

        // Randomized traffic with backpressure and occasional resets.
        repeat (3000) begin
            @(negedge clk);
            parent_valid    = 1'($urandom_range(0, 1));
            parent_a        = $urandom;
            parent_b        = $urandom;
            mode            = 1'($urandom_range(0, 1));
            cfg_en          = 1'($urandom_range(0, 1));
            cfg_sel         = 4'($urandom);
            crossover_ready = ($urandom_range(0, 3) != 0);
            rst             = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        parent_valid = 1'b0;
        crossover_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
